// File: rtl/scan_display.sv
// Multiplexed seven-segment scanner with a shadow register committed only at frame
// boundaries. Optional blinking is built in when SCAN_DISPLAY_BLINK_EN is defined.
module scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 16000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    frame_done_q;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    term_cnt, boundary, phase;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    visible;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = ~7'h3F;
            4'h1: hex_glyph = ~7'h06;
            4'h2: hex_glyph = ~7'h5B;
            4'h3: hex_glyph = ~7'h4F;
            4'h4: hex_glyph = ~7'h66;
            4'h5: hex_glyph = ~7'h6D;
            4'h6: hex_glyph = ~7'h7D;
            4'h7: hex_glyph = ~7'h07;
            4'h8: hex_glyph = ~7'h7F;
            4'h9: hex_glyph = ~7'h6F;
            4'hA: hex_glyph = ~7'h77;
            4'hB: hex_glyph = ~7'h7C;
            4'hC: hex_glyph = ~7'h39;
            4'hD: hex_glyph = ~7'h5E;
            4'hE: hex_glyph = ~7'h79;
            4'hF: hex_glyph = ~7'h71;
        endcase
    endfunction

    // load is a fire-and-forget strobe with no back-pressure: it is always accepted,
    // and pending reports that the shadow still waits for the next frame boundary.
    always_comb begin
        term_cnt  = (cnt_q == CNT_LAST);
        boundary  = term_cnt && (idx_q == IDX_LAST);
        cnt_d     = term_cnt ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (term_cnt) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        // A load on the boundary still lands in the shadow after the old one commits.
        if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        nibble = 4'h0;
        an_sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nibble    = active_q[4*k +: 4];
                an_sel[k] = 1'b0;
            end
        end
        visible = |(~an_sel & digit_en & ~(blink_mask & {NUM_DIGITS{phase}}));
        seg_d   = visible ? hex_glyph(nibble) : 7'h7F;
        an_d    = visible ? an_sel : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= 7'h7F;
            an_q         <= '1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= boundary;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

`ifdef SCAN_DISPLAY_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (boundary) begin
            if (fcnt_q == FRAME_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    assign phase = 1'b0;
`endif

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_scan_display.sv
// Directed bench for scan_display with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// Edge n counts rising clock edges since reset release; outputs are sampled 1 ns after.
module tb_scan_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  blink_mask = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    int edge_n   = 0;
    int n_checks = 0;
    int n_fail   = 0;

`ifdef SCAN_DISPLAY_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    scan_display #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_in (digits_in),
        .load      (load),
        .digit_en  (digit_en),
        .blink_mask(blink_mask),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Active-low glyphs, bit 0 = segment a.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) cyc();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] val);
        digits_in = val;
        load      = 1'b1;
        cyc();
        load      = 1'b0;
    endtask

    // Edge n shows slot ((n-1)/4)%4 of the value committed at the preceding boundary.
    task automatic scan(input logic [15:0] val, input int from, input int to,
                        input logic [3:0] en, input logic [3:0] bm, input bit ph);
        int          slot;
        logic        vis;
        logic [3:0]  an_e;
        for (int n = from; n <= to; n++) begin
            run_to(n);
            slot = ((n - 1) / 4) % 4;
            vis  = en[slot] && !(bm[slot] && ph);
            an_e = 4'hF;
            if (vis) an_e[slot] = 1'b0;
            chk("an", {12'h0, an}, {12'h0, an_e});
            chk("seg", {9'h0, seg}, vis ? {9'h0, glyph(val[4*slot +: 4])} : 16'h007F);
            chk("frame_done", {15'h0, frame_done}, {15'h0, (n % 16 == 0)});
        end
    endtask

    initial begin
        #12;
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_frame_done", {15'h0, frame_done}, 16'h0);
        chk("rst_pending", {15'h0, pending}, 16'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;

        // Case 1: first frame shows the reset value, then 1234.
        do_load(16'h1234);
        chk("pend_after_load", {15'h0, pending}, 16'h1);
        scan(16'h0000, 1, 16, 4'hF, 4'h0, 1'b0);
        chk("pend_after_commit", {15'h0, pending}, 16'h0);
        scan(16'h1234, 17, 40, 4'hF, 4'h0, 1'b0);

        // Case 2: mid-frame load waits for the boundary.
        do_load(16'hABCD);
        chk("pend_mid_frame", {15'h0, pending}, 16'h1);
        scan(16'h1234, 41, 47, 4'hF, 4'h0, 1'b0);
        chk("pend_before_boundary", {15'h0, pending}, 16'h1);
        scan(16'h1234, 48, 48, 4'hF, 4'h0, 1'b0);
        chk("pend_at_boundary", {15'h0, pending}, 16'h0);
        scan(16'hABCD, 49, 65, 4'hF, 4'h0, 1'b0);

        // Case 3: two loads in one frame, last one wins.
        do_load(16'h1111);
        scan(16'hABCD, 66, 69, 4'hF, 4'h0, 1'b0);
        do_load(16'h2222);
        scan(16'hABCD, 70, 80, 4'hF, 4'h0, 1'b0);
        scan(16'h2222, 81, 99, 4'hF, 4'h0, 1'b0);

        // Case 4: load on the boundary edge while 5555 is pending.
        do_load(16'h5555);
        chk("pend_5555", {15'h0, pending}, 16'h1);
        scan(16'h2222, 100, 111, 4'hF, 4'h0, 1'b0);
        do_load(16'h6789);
        chk("pend_on_boundary_load", {15'h0, pending}, 16'h1);
        scan(16'h2222, 112, 112, 4'hF, 4'h0, 1'b0);
        scan(16'h5555, 113, 128, 4'hF, 4'h0, 1'b0);
        chk("pend_6789_committed", {15'h0, pending}, 16'h0);
        scan(16'h6789, 129, 144, 4'hF, 4'h0, 1'b0);

        // Case 5: live digit enables blank slots 0 and 2.
        digit_en = 4'b1010;
        scan(16'h6789, 145, 160, 4'b1010, 4'h0, 1'b0);

        // Case 6: blink on digit 0; phase is 1 for frames after boundaries 160 and 176.
        digit_en   = 4'hF;
        blink_mask = 4'b0001;
        scan(16'h6789, 161, 192, 4'hF, 4'b0001, BLINK_ON);
        scan(16'h6789, 193, 224, 4'hF, 4'b0001, 1'b0);

        // Reset in the middle of a frame with a load pending.
        blink_mask = 4'h0;
        run_to(230);
        do_load(16'h1111);
        chk("pend_before_reset", {15'h0, pending}, 16'h1);
        run_to(233);
        rst_n = 1'b0;
        #1;
        chk("midrst_seg", {9'h0, seg}, 16'h007F);
        chk("midrst_an", {12'h0, an}, 16'h000F);
        chk("midrst_frame_done", {15'h0, frame_done}, 16'h0);
        chk("midrst_pending", {15'h0, pending}, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("held_rst_seg", {9'h0, seg}, 16'h007F);
        chk("held_rst_an", {12'h0, an}, 16'h000F);
        rst_n  = 1'b1;
        edge_n = 0;
        scan(16'h0000, 1, 16, 4'hF, 4'h0, 1'b0);
        chk("pend_discarded", {15'h0, pending}, 16'h0);
        scan(16'h0000, 17, 32, 4'hF, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_display.md
SCAN_DISPLAY -- requirements
Module: scan_display

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed seven-segment digits (legal 1..8).
REQ-002 The module SHALL have parameter REFRESH_DIV, default 16000, meaning the clk cycles each digit is driven per scan slot (legal >= 2).
REQ-003 The module SHALL have parameter BLINK_FRAMES, default 64, meaning the full scan frames per blink half-period (legal >= 1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port digits_in, input, 4*NUM_DIGITS bits: nibble k ([4k+3:4k]) is the hex value of digit k, where digit 0 is rightmost.
REQ-007 The module SHALL have port load, input, 1 bit: a one-cycle strobe that captures digits_in into the shadow register.
REQ-008 The module SHALL have port digit_en, input, NUM_DIGITS bits: a per-digit enable; 0 blanks the digit.
REQ-009 The module SHALL have port blink_mask, input, NUM_DIGITS bits: a per-digit blink select.
REQ-010 The module SHALL have port seg, output, 7 bits: active-low segments, with seg[0]=a through seg[6]=g.
REQ-011 The module SHALL have port an, output, NUM_DIGITS bits: active-low anodes, with an[k] selecting digit k.
REQ-012 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse asserted at each frame boundary.
REQ-013 The module SHALL have port pending, output, 1 bit: high while the shadow holds data not yet committed.

Function
REQ-014 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the terminal count is cycle REFRESH_DIV-1.
REQ-015 On terminal count, the digit index SHALL advance k -> k+1, wrapping from NUM_DIGITS-1 to 0.
REQ-016 A frame boundary SHALL be terminal count while index = NUM_DIGITS-1; frame_done SHALL pulse exactly one cycle after it.
REQ-017 load=1 SHALL copy digits_in to the shadow and set pending on the next edge; a later load before commit SHALL overwrite the shadow (last write wins).
REQ-018 At a frame boundary with pending=1, the shadow SHALL be copied to the active register and pending SHALL clear, so a displayed frame never mixes old and new values.
REQ-019 load coincident with a frame boundary SHALL commit the previously pending shadow (if any); the new value SHALL stay pending until the following boundary.
REQ-020 seg and an SHALL be registered, reflecting the current index one cycle after the index changes; exactly one an bit SHALL be low when a digit is visible.
REQ-021 seg SHALL decode the active nibble 0-F to the standard hex glyphs (0-9, A, b, C, d, E, F), with every code fully defined.
REQ-022 A digit SHALL be visible only if its digit_en bit is 1 and it is not blink-blanked; a non-visible slot SHALL drive an all-ones and seg=7'h7F.
REQ-023 digit_en and blink_mask SHALL be sampled live each cycle and SHALL NOT be shadowed.

Reset
REQ-024 While rst_n=0: refresh counter=0, index=0, active=0, shadow=0, pending=0, frame_done=0, blink phase=0, seg=7'h7F, an all ones.
REQ-025 Reset asserted mid-frame or mid-pending SHALL discard the shadow; after release, scanning SHALL restart at digit 0 with count 0.

Configuration
REQ-026 With macro SCAN_DISPLAY_BLINK_EN defined, a frame counter SHALL toggle the blink phase every BLINK_FRAMES frame boundaries, and digits with blink_mask=1 SHALL be blanked while phase=1.
REQ-027 Without SCAN_DISPLAY_BLINK_EN, the blink counter SHALL be absent, blink_mask SHALL be ignored, phase SHALL be constantly 0, and the port list SHALL be unchanged.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-028 Bench case 1: release reset, digit_en=4'hF, load 16'h1234 -> after the first boundary, the an sequence is 1110,1101,1011,0111, each held 4 cycles, with seg showing 4,3,2,1; frame_done pulses every 16 cycles.
REQ-029 Bench case 2: load 16'hABCD mid-frame -> pending=1, and the current frame finishes showing the old digits; ABCD first appears in the slot after frame_done, and pending then reads 0.
REQ-030 Bench case 3: load 16'h1111 then 16'h2222 in the same frame -> only 2222 is ever displayed.
REQ-031 Bench case 4: load on the boundary cycle while 16'h5555 is pending -> 5555 commits, and the new value commits one frame later.
REQ-032 Bench case 5: digit_en=4'b1010 -> slots 0 and 2 drive an=1111 and seg=7F.
REQ-033 Bench case 6: with the macro defined and blink_mask=4'b0001, digit 0 is dark for 2 frames and lit for 2 frames, alternating; with the macro undefined it is always lit. A reset pulse mid-frame returns all outputs to their reset values immediately.
